checker_mode_read: RTL and testbench

CHECKER_MODE_READ -- requirements
Module: checker_mode_read

---
 rtl/checker_mode_read.sv | 171 +++++++++++++++++
 tb/tb_checker_mode_read.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/checker_mode_read.sv
// Mode-gated memory read engine.
// A rising edge on mode_start, seen while this engine's mode is selected, reads WORDS
// consecutive 64-bit words starting at mode_addr (8-byte aligned). The words are
// XOR-folded into an accumulator. A word with bit 63 set pauses the run behind an
// interrupt until software acknowledges it. The run ends with a one-cycle mode_end
// pulse, plus mode_error if a bus error or a per-word timeout occurred. Dropping
// mode_start mid-run aborts silently.
module checker_mode_read #(
  parameter logic [1:0]  MODE_ID = 2'b01,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  mode_mode,
  input  logic        mode_start,
  input  logic [63:0] mode_addr,
  output logic        mode_end,
  output logic [63:0] mode_data,
  output logic        mode_irq,
  input  logic        mode_ack,
  output logic        mode_error,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  input  logic        mem_err
);

  localparam logic [7:0] WordsLim = WORDS[7:0];
  // Failure fires on the wait cycle that would take the counter to TIMEOUT.
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StIrq, StDone} state_e;

  state_e      state_q, state_d;
  logic        start_q;
  logic        valid_q;   // start_q holds a genuine post-reset sample
  logic [63:0] acc_q, acc_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic [63:0] data_q, data_d;

  logic        start_rise;
  logic [7:0]  cnt_inc;
  logic [63:0] acc_fold;

  assign start_rise = mode_start & ~start_q & valid_q & (mode_mode == MODE_ID);
  assign cnt_inc    = cnt_q + 8'd1;
  assign acc_fold   = acc_q ^ mem_data;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= mode_start;
      valid_q <= 1'b1;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: abort beats every other event in REQ and IRQ.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    req_d   = req_q;
    err_d   = err_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          addr_d  = mode_addr & ~64'h7;
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end

      StReq: begin
        if (!mode_start) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (!req_q) begin
          // Gap cycle after a completed read: issue the next request.
          req_d = 1'b1;
          tmo_d = '0;
        end else if (mem_ack) begin
          req_d = 1'b0;
          if (mem_err) begin
            err_d   = 1'b1;
            data_d  = acc_q;
            state_d = StDone;
          end else begin
            acc_d  = acc_fold;
            addr_d = addr_q + 64'd8;
            cnt_d  = cnt_inc;
            if (mem_data[63]) begin
              state_d = StIrq;
            end else if (cnt_inc == WordsLim) begin
              data_d  = acc_fold;
              state_d = StDone;
            end
          end
        end else if (tmo_q == TmoLast) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          data_d  = acc_q;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      StIrq: begin
        if (!mode_start) begin
          state_d = StIdle;
        end else if (mode_ack) begin
          if (cnt_q == WordsLim) begin
            data_d  = acc_q;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mode_end   = (state_q == StDone);
  assign mode_error = (state_q == StDone) & err_q;
  assign mode_irq   = (state_q == StIrq);
  assign mode_data  = data_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;

endmodule

// File: tb/tb_checker_mode_read.sv
// Directed bench for checker_mode_read with default parameters
// (MODE_ID=2'b01, WORDS=4, TIMEOUT=255).
module tb_checker_mode_read;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  mode_mode;
  logic        mode_start;
  logic [63:0] mode_addr;
  logic        mode_end;
  logic [63:0] mode_data;
  logic        mode_irq;
  logic        mode_ack;
  logic        mode_error;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  checker_mode_read dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .mode_mode  (mode_mode),
    .mode_start (mode_start),
    .mode_addr  (mode_addr),
    .mode_end   (mode_end),
    .mode_data  (mode_data),
    .mode_irq   (mode_irq),
    .mode_ack   (mode_ack),
    .mode_error (mode_error),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .mem_err    (mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Low-then-high on mode_start; the run's first request is visible on return.
  task automatic go(input logic [63:0] addr);
    mode_addr  = addr;
    mode_start = 1'b0;
    step();
    mode_start = 1'b1;
    step();
  endtask

  // Serve one read with a single wait cycle before the acknowledge.
  task automatic serve(input string tag, input logic [63:0] addr, input logic [63:0] data,
                       input logic err);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {63'd0, mem_req}, 64'd1);
    chk({tag, "_addr"}, mem_addr, addr);
    step();
    chk({tag, "_hold"}, {63'd0, mem_req}, 64'd1);
    chk({tag, "_stable"}, mem_addr, addr);
    mem_ack  = 1'b1;
    mem_data = data;
    mem_err  = err;
    step();
    mem_ack  = 1'b0;
    mem_err  = 1'b0;
    mem_data = '0;
    chk({tag, "_drop"}, {63'd0, mem_req}, 64'd0);
  endtask

  initial begin
    int n;
    sys_rst    = 1'b0;
    mode_mode  = 2'b01;
    mode_start = 1'b1;
    mode_addr  = '0;
    mode_ack   = 1'b0;
    mem_ack    = 1'b0;
    mem_data   = '0;
    mem_err    = 1'b0;

    // Reset with start already high.
    repeat (3) step();
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_end", {63'd0, mode_end}, 64'd0);
    chk("rst_irq", {63'd0, mode_irq}, 64'd0);
    chk("rst_err", {63'd0, mode_error}, 64'd0);
    chk("rst_data", mode_data, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    sys_rst  = 1'b1;
    mode_ack = 1'b1;  // ack outside IRQ is ignored
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_start_noreq", {63'd0, mem_req}, 64'd0);
    end
    mode_ack = 1'b0;

    // Normal run.
    go(64'h1003);
    serve("n0", 64'h1000, 64'h1, 1'b0);
    serve("n1", 64'h1008, 64'h2, 1'b0);
    serve("n2", 64'h1010, 64'h4, 1'b0);
    serve("n3", 64'h1018, 64'h8, 1'b0);
    chk("n_end", {63'd0, mode_end}, 64'd1);
    chk("n_err", {63'd0, mode_error}, 64'd0);
    chk("n_data", mode_data, 64'hF);
    step();
    chk("n_end_pulse", {63'd0, mode_end}, 64'd0);
    chk("n_data_hold", mode_data, 64'hF);

    // IRQ run.
    go(64'h2000);
    serve("i0", 64'h2000, 64'h1, 1'b0);
    serve("i1", 64'h2008, 64'h8000000000000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("i_irq", {63'd0, mode_irq}, 64'd1);
      chk("i_noreq", {63'd0, mem_req}, 64'd0);
      step();
    end
    mode_ack = 1'b1;
    step();
    mode_ack = 1'b0;
    chk("i_irq_clr", {63'd0, mode_irq}, 64'd0);
    serve("i2", 64'h2010, 64'h2, 1'b0);
    serve("i3", 64'h2018, 64'h4, 1'b0);
    chk("i_end", {63'd0, mode_end}, 64'd1);
    chk("i_err", {63'd0, mode_error}, 64'd0);
    chk("i_data", mode_data, 64'h8000000000000007);

    // Bus error on word 3.
    go(64'h3000);
    serve("e0", 64'h3000, 64'h1, 1'b0);
    serve("e1", 64'h3008, 64'h2, 1'b0);
    serve("e2", 64'h3010, 64'hFF, 1'b1);
    chk("e_end", {63'd0, mode_end}, 64'd1);
    chk("e_err", {63'd0, mode_error}, 64'd1);
    chk("e_data", mode_data, 64'h3);
    step();
    chk("e_err_pulse", {63'd0, mode_error}, 64'd0);

    // Abort during word 2, coinciding with its acknowledge.
    go(64'h4000);
    serve("a0", 64'h4000, 64'h10, 1'b0);
    step();
    chk("a_req2", {63'd0, mem_req}, 64'd1);
    chk("a_addr2", mem_addr, 64'h4008);
    mode_start = 1'b0;
    mem_ack    = 1'b1;
    mem_data   = 64'h20;
    step();
    mem_ack  = 1'b0;
    mem_data = '0;
    chk("a_noreq", {63'd0, mem_req}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("a_noend", {63'd0, mode_end | mode_error}, 64'd0);
      chk("a_data", mode_data, 64'h3);
      step();
    end

    // Mode mismatch, then address wrap.
    mode_mode = 2'b10;
    go(64'h5000);
    for (int i = 0; i < 4; i++) begin
      chk("m_noreq", {63'd0, mem_req}, 64'd0);
      step();
    end
    mode_mode = 2'b01;
    go(64'hFFFFFFFFFFFFFFF8);
    serve("w0", 64'hFFFFFFFFFFFFFFF8, 64'h1, 1'b0);
    serve("w1", 64'h0, 64'h2, 1'b0);
    serve("w2", 64'h8, 64'h4, 1'b0);
    serve("w3", 64'h10, 64'h8, 1'b0);
    chk("w_end", {63'd0, mode_end}, 64'd1);
    chk("w_data", mode_data, 64'hF);

    // Timeout: no mem_ack at all.
    go(64'h6000);
    chk("t_req", {63'd0, mem_req}, 64'd1);
    n = 0;
    while (mode_end !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("t_end", {63'd0, mode_end}, 64'd1);
    chk("t_cycles", 64'(n), 64'd255);
    chk("t_err", {63'd0, mode_error}, 64'd1);
    chk("t_data", mode_data, 64'h0);

    // Reset mid-run.
    go(64'h7000);
    chk("r_req", {63'd0, mem_req}, 64'd1);
    sys_rst = 1'b0;
    step();
    chk("r_req0", {63'd0, mem_req}, 64'd0);
    chk("r_addr0", mem_addr, 64'd0);
    chk("r_data0", mode_data, 64'd0);
    chk("r_end0", {63'd0, mode_end | mode_error | mode_irq}, 64'd0);
    sys_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("r_quiet", {62'd0, mode_end, mem_req}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
